// File: rtl/uart_pkg.sv
// Shared types and limits for the UART receive path: FSM states, oversample
// bounds, default divisor width, error-flag bundle and the 3-sample vote.
package uart_pkg;

  localparam int unsigned UART_OVS_MIN   = 8;
  localparam int unsigned UART_OVS_MAX   = 16;
  localparam int unsigned UART_DIV_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  typedef struct packed {
    logic frame;
    logic parity;
    logic overrun;
  } uart_err_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every div+1 clocks, reloaded on
// sync so the tick phase lines up with a detected start edge.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = UART_DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             sync,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == '0);
    cnt_d = cnt_q - DIV_W'(1);
    if (sync || tick) cnt_d = div;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with oversampled majority vote and valid/ack
// output register. Optional parity bit enabled by `define UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned      DATA_W  = 8,
  parameter int unsigned      OVS     = 16,
  parameter int unsigned      DIV_W   = UART_DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_ld,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_par_odd,
  input  logic              rx_si,
  input  logic              rx_data_ack,
  output logic [DATA_W-1:0] rx_po,
  output logic              rx_valid,
  output logic              rx_busy,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_overrun
);

  localparam int unsigned TCW = $clog2(OVS);
  localparam int unsigned BCW = $clog2(DATA_W);
  localparam int unsigned MID = OVS / 2;

  if (OVS < UART_OVS_MIN || OVS > UART_OVS_MAX || (OVS % 2) != 0) begin : g_bad_ovs
    $error("uart_rx_param: OVS must be even and within 8..16");
  end

  logic [1:0]        sync_q, sync_d;
  logic              prev_q, prev_d;
  logic [1:0]        samp_q, samp_d;
  logic [DIV_W-1:0]  div_q, div_d;
  uart_state_e       state_q, state_d;
  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] po_q, po_d;
  logic              valid_q, valid_d;
  uart_err_t         err_q, err_d;

  logic rx_s, falling, tick, start_det, commit, frame_bad, vote, in_win, mid;
  logic par_err;

`ifdef UART_RX_PARITY_EN
  logic par_odd_q, par_odd_d, par_err_q, par_err_d;
  assign par_err = par_err_q;
`else
  logic unused_cfg_par_odd;
  assign unused_cfg_par_odd = cfg_par_odd;
  assign par_err            = 1'b0;
`endif

  assign rx_s    = sync_q[1];
  assign falling = prev_q & ~rx_s;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .div   (div_q),
    .sync  (start_det),
    .tick  (tick)
  );

  always_comb begin
    sync_d = {sync_q[0], rx_si};
    prev_d = rx_s;
    div_d  = div_q;
`ifdef UART_RX_PARITY_EN
    par_odd_d = par_odd_q;
`endif
    if (cfg_ld && !en) begin
      div_d = cfg_div;
`ifdef UART_RX_PARITY_EN
      par_odd_d = cfg_par_odd;
`endif
    end
  end

  // tick_cnt free-runs modulo OVS from the start edge, so it wraps to 0 exactly
  // at each bit boundary and every bit is voted at its centre (tick OVS/2).
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    shreg_d    = shreg_q;
`ifdef UART_RX_PARITY_EN
    par_err_d  = par_err_q;
`endif
    start_det  = 1'b0;
    commit     = 1'b0;
    frame_bad  = 1'b0;
    in_win     = (tick_cnt_q >= TCW'(MID - 2)) && (tick_cnt_q <= TCW'(MID));
    mid        = (tick_cnt_q == TCW'(MID));
    vote       = maj3({samp_q, rx_s});

    if (state_q == ST_IDLE) begin
      if (falling) begin
        state_d    = ST_START;
        start_det  = 1'b1;
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        samp_d     = '1;
      end
    end else if (tick) begin
      tick_cnt_d = (tick_cnt_q == TCW'(OVS - 1)) ? '0 : tick_cnt_q + TCW'(1);
      if (in_win) samp_d = {samp_q[0], rx_s};
      if (mid) begin
        case (state_q)
          ST_START: state_d = vote ? ST_IDLE : ST_DATA;
          ST_DATA: begin
            shreg_d = {vote, shreg_q[DATA_W-1:1]};
            if (bit_cnt_q == BCW'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            par_err_d = vote ^ (^shreg_q) ^ par_odd_q;
            state_d   = ST_STOP;
          end
`endif
          ST_STOP: begin
            commit    = 1'b1;
            frame_bad = ~vote;
            state_d   = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (!en) begin
      state_d   = ST_IDLE;
      start_det = 1'b0;
      commit    = 1'b0;
    end
  end

  always_comb begin
    po_d    = po_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (rx_data_ack && valid_q) begin
      valid_d = 1'b0;
      err_d   = '0;
    end
    if (commit) begin
      if (!valid_q || rx_data_ack) begin
        po_d          = shreg_q;
        valid_d       = 1'b1;
        err_d.frame   = frame_bad;
        err_d.parity  = par_err;
        err_d.overrun = 1'b0;
      end else begin
        err_d.overrun = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      prev_q     <= 1'b1;
      samp_q     <= '1;
      div_q      <= DIV_RST;
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      po_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= '0;
`ifdef UART_RX_PARITY_EN
      par_odd_q  <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      samp_q     <= samp_d;
      div_q      <= div_d;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      po_q       <= po_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
`ifdef UART_RX_PARITY_EN
      par_odd_q  <= par_odd_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign rx_po         = po_q;
  assign rx_valid      = valid_q;
  assign rx_busy       = (state_q != ST_IDLE);
  assign rx_frame_err  = err_q.frame;
  assign rx_parity_err = err_q.parity;
  assign rx_overrun    = err_q.overrun;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: table-driven frames through a
// scoreboard queue plus hand-written glitch, overrun, ack and reset sequences.
module tb_uart_rx_param;

  localparam int unsigned BIT   = 16;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned STOP_IDX = 10;
`else
  localparam int unsigned STOP_IDX = 9;
`endif
  // Clocks from the first negedge showing rx_busy to the STOP vote cycle.
  localparam int unsigned STOP_VOTE = BIT / 2 + BIT * STOP_IDX;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        cfg_ld = 1'b0;
  logic [15:0] cfg_div = '0;
  logic        cfg_par_odd = 1'b0;
  logic        rx_si = 1'b1;
  logic        rx_data_ack = 1'b0;
  logic [7:0]  rx_po;
  logic        rx_valid, rx_busy, rx_frame_err, rx_parity_err, rx_overrun;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned wcnt;
  logic        saw_busy;

  typedef struct {
    logic [7:0] po;
    logic       fe;
    logic       pe;
    logic       ov;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[5];

  uart_rx_param #(
    .DATA_W  (8),
    .OVS     (16),
    .DIV_W   (16),
    .DIV_RST (16'd0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .cfg_ld        (cfg_ld),
    .cfg_div       (cfg_div),
    .cfg_par_odd   (cfg_par_odd),
    .rx_si         (rx_si),
    .rx_data_ack   (rx_data_ack),
    .rx_po         (rx_po),
    .rx_valid      (rx_valid),
    .rx_busy       (rx_busy),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .rx_overrun    (rx_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    rx_si = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_si = d[i];
      repeat (BIT) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx_si = par_b;
    repeat (BIT) @(negedge clk);
`else
    if (par_b === 1'bx) rx_si = 1'b1;
`endif
    rx_si = stop_b;
    repeat (BIT) @(negedge clk);
    rx_si = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    exp_t e;
    int unsigned w = 0;
    while (!rx_valid && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("%s valid", tag), rx_valid, 1);
    if (exp_q.size() == 0) begin
      chk($sformatf("%s scoreboard empty", tag), 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("%s rx_po", tag), rx_po, e.po);
      chk($sformatf("%s frame_err", tag), rx_frame_err, e.fe);
      chk($sformatf("%s parity_err", tag), rx_parity_err, e.pe);
      chk($sformatf("%s overrun", tag), rx_overrun, e.ov);
    end
  endtask

  task automatic do_ack(input string tag);
    rx_data_ack = 1'b1;
    @(negedge clk);
    rx_data_ack = 1'b0;
    chk($sformatf("%s valid after ack", tag), rx_valid, 0);
    chk($sformatf("%s flags after ack", tag), {rx_frame_err, rx_parity_err, rx_overrun}, 0);
  endtask

  task automatic load_cfg(input logic odd);
    en = 1'b0;
    @(negedge clk);
    cfg_ld = 1'b1;
    cfg_div = 16'd0;
    cfg_par_odd = odd;
    @(negedge clk);
    cfg_ld = 1'b0;
    en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, exp_fe: 1'b1};
    vecs[2] = '{data: 8'h00, stop: 1'b1, exp_fe: 1'b0};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, exp_fe: 1'b0};
    vecs[4] = '{data: 8'hC3, stop: 1'b1, exp_fe: 1'b0};

    // Reset state
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rx_po", rx_po, 0);
    chk("reset valid", rx_valid, 0);
    chk("reset busy", rx_busy, 0);
    chk("reset flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    rst_n = 1'b1;
    load_cfg(1'b0);

    // Table-driven frames, each acked
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back('{po: vecs[v].data, fe: vecs[v].exp_fe, pe: 1'b0, ov: 1'b0});
      send_frame(vecs[v].data, vecs[v].stop, ^vecs[v].data);
      check_frame($sformatf("vec%0d", v));
      do_ack($sformatf("vec%0d", v));
    end

    // Ack while rx_valid=0 changes nothing
    rx_data_ack = 1'b1;
    repeat (3) @(negedge clk);
    rx_data_ack = 1'b0;
    @(negedge clk);
    chk("idle ack valid", rx_valid, 0);
    chk("idle ack rx_po", rx_po, 8'hC3);
    chk("idle ack flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);

    // Short low glitch is rejected as a false start
    saw_busy = 1'b0;
    rx_si = 1'b0;
    repeat (6) @(negedge clk);
    rx_si = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_busy) saw_busy = 1'b1;
    end
    chk("glitch busy pulse", saw_busy, 1);
    chk("glitch busy end", rx_busy, 0);
    chk("glitch valid", rx_valid, 0);
    chk("glitch flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);

`ifdef UART_RX_PARITY_EN
    load_cfg(1'b1);
    exp_q.push_back('{po: 8'h01, fe: 1'b0, pe: 1'b1, ov: 1'b0});
    send_frame(8'h01, 1'b1, 1'b1);
    check_frame("odd parity bad");
    do_ack("odd parity bad");
    exp_q.push_back('{po: 8'h01, fe: 1'b0, pe: 1'b0, ov: 1'b0});
    send_frame(8'h01, 1'b1, 1'b0);
    check_frame("odd parity good");
    do_ack("odd parity good");
    load_cfg(1'b0);
`endif

    // Overrun: second frame discarded while the first is unacknowledged
    send_frame(8'h11, 1'b1, ^8'h11);
    exp_q.push_back('{po: 8'h11, fe: 1'b0, pe: 1'b0, ov: 1'b1});
    send_frame(8'h22, 1'b1, ^8'h22);
    check_frame("overrun");

    // Ack coinciding with the commit clock loads the new frame and clears overrun
    exp_q.push_back('{po: 8'h22, fe: 1'b0, pe: 1'b0, ov: 1'b0});
    fork
      send_frame(8'h22, 1'b1, ^8'h22);
      begin
        wcnt = 0;
        while (!rx_busy && wcnt < 100) begin
          @(negedge clk);
          wcnt++;
        end
        chk("commit-ack busy seen", rx_busy, 1);
        repeat (STOP_VOTE) @(negedge clk);
        rx_data_ack = 1'b1;
        @(negedge clk);
        rx_data_ack = 1'b0;
        chk("commit-ack valid held", rx_valid, 1);
      end
    join
    check_frame("commit-ack");

    // Reset during data bit 4 clears everything immediately
    rx_si = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_si = (8'h5A >> i) & 8'h01;
      repeat (BIT) @(negedge clk);
    end
    rx_si = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    chk("midframe busy", rx_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe rst rx_po", rx_po, 0);
    chk("midframe rst valid", rx_valid, 0);
    chk("midframe rst busy", rx_busy, 0);
    chk("midframe rst flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    exp_q.push_back('{po: 8'h5A, fe: 1'b0, pe: 1'b0, ov: 1'b0});
    send_frame(8'h5A, 1'b1, ^8'h5A);
    check_frame("post-reset");
    do_ack("post-reset");

    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
